// File: rtl/commit_controller.sv
// In-order commit sequencer: retires the ROB head into the register file, holds
// stores until the memory port accepts them, and sequences mispredict flushes.
module commit_controller #(
   parameter int DATA_W       = 32,
   parameter int REG_W        = 5,
   parameter int TAG_W        = 4,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              head_valid,
   input  logic              head_ready,
   input  logic [TAG_W-1:0]  head_tag,
   input  logic              head_has_rd,
   input  logic [REG_W-1:0]  head_rd,
   input  logic [DATA_W-1:0] head_value,
   input  logic              head_is_store,
   input  logic [DATA_W-1:0] head_addr,
   input  logic              head_mispredict,
   input  logic [DATA_W-1:0] head_target,
   input  logic              mem_ack,
   output logic              rob_decrement,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_rd,
   output logic [DATA_W-1:0] rf_value,
   output logic [TAG_W-1:0]  rf_tag,
   output logic              mem_req,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              flush,
   output logic [DATA_W-1:0] redirect_pc,
   output logic [CNT_W-1:0]  retired_count
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

   typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;

   state_t          state;
   logic [FC_W-1:0] flush_cnt;
   logic            go;

   // Retire strobes are Mealy so a ready non-store head leaves in the same cycle.
   always_comb begin
      go            = head_valid & head_ready;
      rob_decrement = 1'b0;
      rf_we         = 1'b0;
      if (!reset) begin
         case (state)
            RUN: begin
               rob_decrement = go & ~head_is_store;
               rf_we         = go & ~head_is_store & head_has_rd;
            end
            STORE_WAIT: rob_decrement = mem_ack;
            default: begin
               rob_decrement = 1'b0;
               rf_we         = 1'b0;
            end
         endcase
      end
      rf_rd    = rf_we ? head_rd    : '0;
      rf_value = rf_we ? head_value : '0;
      rf_tag   = rf_we ? head_tag   : '0;
   end

   // mem_req and flush are registered alongside the state so they never see head inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RUN;
         mem_req       <= 1'b0;
         flush         <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         redirect_pc   <= '0;
         retired_count <= '0;
         flush_cnt     <= '0;
      end else begin
         if (rob_decrement) retired_count <= retired_count + CNT_W'(1);
         case (state)
            RUN: begin
               if (go && head_is_store) begin
                  mem_addr  <= head_addr;
                  mem_wdata <= head_value;
                  mem_req   <= 1'b1;
                  state     <= STORE_WAIT;
               end else if (go && head_mispredict) begin
                  redirect_pc <= head_target;
                  flush_cnt   <= FC_W'(FLUSH_CYCLES);
                  flush       <= 1'b1;
                  state       <= FLUSH;
               end
            end
            STORE_WAIT: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= RUN;
               end
            end
            FLUSH: begin
               if (flush_cnt == FC_W'(1)) begin
                  flush <= 1'b0;
                  state <= RUN;
               end else begin
                  flush_cnt <= flush_cnt - FC_W'(1);
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_commit_controller.sv
// Directed bench for commit_controller: ALU retires, stores, mispredict flush,
// reset recovery and retired-count wrap with a 4-bit counter.
module tb_commit_controller;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int TAG_W  = 4;
   localparam int FC     = 2;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              head_valid, head_ready, head_has_rd, head_is_store, head_mispredict;
   logic [TAG_W-1:0]  head_tag;
   logic [REG_W-1:0]  head_rd;
   logic [DATA_W-1:0] head_value, head_addr, head_target;
   logic              mem_ack;
   logic              rob_decrement, rf_we, mem_req, flush;
   logic [REG_W-1:0]  rf_rd;
   logic [DATA_W-1:0] rf_value, mem_addr, mem_wdata, redirect_pc;
   logic [TAG_W-1:0]  rf_tag;
   logic [CNT_W-1:0]  retired_count;

   int total = 0;
   int bad   = 0;

   commit_controller #(
      .DATA_W(DATA_W), .REG_W(REG_W), .TAG_W(TAG_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .head_valid(head_valid), .head_ready(head_ready), .head_tag(head_tag),
      .head_has_rd(head_has_rd), .head_rd(head_rd), .head_value(head_value),
      .head_is_store(head_is_store), .head_addr(head_addr),
      .head_mispredict(head_mispredict), .head_target(head_target),
      .mem_ack(mem_ack), .rob_decrement(rob_decrement), .rf_we(rf_we),
      .rf_rd(rf_rd), .rf_value(rf_value), .rf_tag(rf_tag),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .flush(flush), .redirect_pc(redirect_pc), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_head(input logic v, input logic st, input logic mp, input logic hr,
                           input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] val,
                           input logic [TAG_W-1:0] tg);
      head_valid      = v;
      head_ready      = 1'b1;
      head_is_store   = st;
      head_mispredict = mp;
      head_has_rd     = hr;
      head_rd         = rd;
      head_value      = val;
      head_tag        = tg;
   endtask

   initial begin
      reset       = 1'b1;
      mem_ack     = 1'b0;
      head_addr   = '0;
      head_target = '0;
      set_head(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234, 4'd1);

      // Reset with a ready head present
      @(negedge clk);
      chk("rst_rob_dec", 64'(rob_decrement), 64'd0);
      chk("rst_rf_we", 64'(rf_we), 64'd0);
      chk("rst_rf_rd", 64'(rf_rd), 64'd0);
      chk("rst_mem_req", 64'(mem_req), 64'd0);
      chk("rst_flush", 64'(flush), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_redirect", 64'(redirect_pc), 64'd0);
      chk("rst_count", 64'(retired_count), 64'd0);
      next_cycle();
      reset = 1'b0;
      head_valid = 1'b0;
      @(negedge clk);
      chk("idle_rob_dec", 64'(rob_decrement), 64'd0);
      next_cycle();

      // Back-to-back ALU retires; the third has no destination
      for (int i = 0; i < 4; i++) begin
         set_head(1'b1, 1'b0, 1'b0, (i != 2), REG_W'(i + 1), DATA_W'(32'h10 + i), TAG_W'(i + 8));
         @(negedge clk);
         chk("alu_rob_dec", 64'(rob_decrement), 64'd1);
         chk("alu_rf_we", 64'(rf_we), (i != 2) ? 64'd1 : 64'd0);
         chk("alu_rf_rd", 64'(rf_rd), (i != 2) ? 64'(i + 1) : 64'd0);
         chk("alu_rf_value", 64'(rf_value), (i != 2) ? 64'(32'h10 + i) : 64'd0);
         chk("alu_rf_tag", 64'(rf_tag), (i != 2) ? 64'(i + 8) : 64'd0);
         next_cycle();
      end
      head_valid = 1'b0;
      @(negedge clk);
      chk("alu_count", 64'(retired_count), 64'd4);
      chk("alu_idle_dec", 64'(rob_decrement), 64'd0);
      next_cycle();

      // Store with ack in the third mem_req cycle
      set_head(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'hBEEF, 4'd2);
      head_addr = 32'h100;
      @(negedge clk);
      chk("st_t_rob_dec", 64'(rob_decrement), 64'd0);
      chk("st_t_rf_we", 64'(rf_we), 64'd0);
      chk("st_t_mem_req", 64'(mem_req), 64'd0);
      next_cycle();
      head_addr  = 32'h9999;
      head_value = 32'hDEAD;
      for (int c = 1; c <= 3; c++) begin
         mem_ack = (c == 3);
         @(negedge clk);
         chk("st_mem_req", 64'(mem_req), 64'd1);
         chk("st_mem_addr", 64'(mem_addr), 64'h100);
         chk("st_mem_wdata", 64'(mem_wdata), 64'hBEEF);
         chk("st_rob_dec", 64'(rob_decrement), (c == 3) ? 64'd1 : 64'd0);
         chk("st_rf_we", 64'(rf_we), 64'd0);
         next_cycle();
      end
      mem_ack = 1'b0;
      head_valid = 1'b0;
      @(negedge clk);
      chk("st_done_req", 64'(mem_req), 64'd0);
      chk("st_count", 64'(retired_count), 64'd5);
      next_cycle();

      // Mispredicted branch with link write
      set_head(1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'h20, 4'd5);
      head_target = 32'h400;
      @(negedge clk);
      chk("mp_t_rob_dec", 64'(rob_decrement), 64'd1);
      chk("mp_t_rf_we", 64'(rf_we), 64'd1);
      chk("mp_t_rf_rd", 64'(rf_rd), 64'd31);
      chk("mp_t_rf_value", 64'(rf_value), 64'h20);
      chk("mp_t_flush", 64'(flush), 64'd0);
      next_cycle();
      set_head(1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h55, 4'd6);
      head_target = 32'h888;
      for (int c = 1; c <= FC; c++) begin
         @(negedge clk);
         chk("mp_flush", 64'(flush), 64'd1);
         chk("mp_fl_rob_dec", 64'(rob_decrement), 64'd0);
         chk("mp_fl_rf_we", 64'(rf_we), 64'd0);
         chk("mp_redirect", 64'(redirect_pc), 64'h400);
         next_cycle();
      end
      @(negedge clk);
      chk("mp_after_flush", 64'(flush), 64'd0);
      chk("mp_after_rob_dec", 64'(rob_decrement), 64'd1);
      chk("mp_after_rf_rd", 64'(rf_rd), 64'd2);
      chk("mp_redirect_hold", 64'(redirect_pc), 64'h400);
      next_cycle();
      head_valid = 1'b0;
      @(negedge clk);
      chk("mp_count", 64'(retired_count), 64'd7);
      next_cycle();

      // Store and mispredict both set: store path wins
      set_head(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 32'h77, 4'd3);
      head_addr = 32'h200;
      @(negedge clk);
      chk("sm_t_rob_dec", 64'(rob_decrement), 64'd0);
      next_cycle();
      mem_ack = 1'b1;
      @(negedge clk);
      chk("sm_mem_req", 64'(mem_req), 64'd1);
      chk("sm_flush", 64'(flush), 64'd0);
      chk("sm_mem_addr", 64'(mem_addr), 64'h200);
      chk("sm_rob_dec", 64'(rob_decrement), 64'd1);
      next_cycle();
      mem_ack = 1'b0;
      head_valid = 1'b0;
      @(negedge clk);
      chk("sm_flush2", 64'(flush), 64'd0);
      chk("sm_req_done", 64'(mem_req), 64'd0);
      chk("sm_count", 64'(retired_count), 64'd8);
      next_cycle();

      // Reset while a store is outstanding, then a stray ack
      set_head(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h99, 4'd4);
      head_addr = 32'h300;
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("rs_req_before", 64'(mem_req), 64'd1);
      chk("rs_rob_dec", 64'(rob_decrement), 64'd0);
      next_cycle();
      reset = 1'b0;
      head_valid = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      chk("rs_req_dropped", 64'(mem_req), 64'd0);
      chk("rs_stray_ack", 64'(rob_decrement), 64'd0);
      chk("rs_mem_addr", 64'(mem_addr), 64'd0);
      chk("rs_count", 64'(retired_count), 64'd0);
      next_cycle();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("rs_count2", 64'(retired_count), 64'd0);
      next_cycle();

      // 17 retires on a 4-bit counter wrap to 1
      set_head(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'd0);
      for (int i = 0; i < 17; i++) next_cycle();
      head_valid = 1'b0;
      @(negedge clk);
      chk("wrap_count", 64'(retired_count), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
